// File: rtl/mbldcm_pkg.sv
// Shared definitions for the multi-channel frequency-to-divider converter:
// constant log2, divider FSM encoding and a reference divider function.
package mbldcm_pkg;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input longint unsigned value);
        int r;
        r = 0;
        while ((64'd1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_COMMIT
    } state_t;

    // Divider a channel should end up with for a given target frequency.
    function automatic longint unsigned div_for(input longint unsigned freq_clk,
                                                input longint unsigned stages,
                                                input longint unsigned target);
        longint unsigned n;
        n = freq_clk / stages;
        if (target == 0 || target > n) begin
            return 1;
        end
        return n / target;
    endfunction

endpackage

// File: rtl/mbldcm_freq2div_mc_udiv_seq.sv
// Bit-serial restoring divider. The start cycle already performs the first
// quotient step, so after WN clock edges the quotient is complete and
// oDone pulses for exactly one cycle.
module mbldcm_udiv_seq
    import mbldcm_pkg::*;
#(
    parameter int WN     = 23,
    parameter int pWidth = 32
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iStart,
    input  logic [WN-1:0]     iNum,
    input  logic [pWidth-1:0] iDen,
    output logic              oDone,
    output logic [WN-1:0]     oQuot
);

    localparam int CNTW = clog2(WN + 1);

    logic [pWidth-1:0] rRem;
    logic [pWidth-1:0] rDen;
    logic [WN-1:0]     rQuot;
    logic [CNTW-1:0]   rCnt;
    logic              rActive;

    logic [pWidth-1:0] remIn;
    logic [pWidth-1:0] denUse;
    logic [WN-1:0]     quotIn;
    logic [pWidth:0]   remShift;
    logic [pWidth-1:0] remNext;
    logic [WN-1:0]     quotNext;
    logic              qBit;

    // One restoring step: shift in the next numerator bit, subtract if it fits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        remNext  = '0;
        qBit     = 1'b0;
        remIn    = iStart ? '0   : rRem;
        quotIn   = iStart ? iNum : rQuot;
        denUse   = iStart ? iDen : rDen;
        remShift = {remIn, quotIn[WN-1]};
        if (remShift >= {1'b0, denUse}) begin
            remNext = remShift[pWidth-1:0] - denUse;
            qBit    = 1'b1;
        end else begin
            remNext = remShift[pWidth-1:0];
        end
        quotNext = {quotIn[WN-2:0], qBit};
    end

    // Iteration state: load on start, step while active, pulse done at the end.
    always_ff @(posedge iClock or posedge iReset) begin
        // NOTE: registered state uses non-blocking (<=) so every flop samples pre-edge values.
        if (iReset) begin
            rRem    <= '0;
            rDen    <= '0;
            rQuot   <= '0;
            rCnt    <= '0;
            rActive <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            oDone <= 1'b0;
            if (iStart) begin
                rRem    <= remNext;
                rQuot   <= quotNext;
                rDen    <= iDen;
                rCnt    <= CNTW'(WN - 1);
                rActive <= 1'b1;
            end else if (rActive) begin
                rRem  <= remNext;
                rQuot <= quotNext;
                rCnt  <= rCnt - 1'b1;
                if (rCnt == CNTW'(1)) begin
                    rActive <= 1'b0;
                    oDone   <= 1'b1;
                end
            end
        end
    end

    assign oQuot = rQuot;

endmodule

// File: rtl/mbldcm_freq2div_mc.sv
// Multi-channel frequency-to-divider converter. Each channel's target is
// turned into N/target by one shared serial divider, channels served
// round-robin; 0 and out-of-range targets take a two-cycle fast path.
module mbldcm_freq2div_mc
    import mbldcm_pkg::*;
#(
    parameter int pFreqClock        = 50000000,
    parameter int pTotalPhaseStages = 6,
    parameter int pChannels         = 4,
    parameter int pWidth            = 32,
    localparam int CW = (pChannels > 1) ? clog2(pChannels) : 1
) (
    input  logic                        iClock,
    input  logic                        iReset,
    input  logic                        iLatchFreqTarget,
    input  logic [CW-1:0]               iChannel,
    input  logic [pWidth-1:0]           iFreqTarget,
    input  logic [CW-1:0]               iRdChannel,
    output logic [pWidth-1:0]           oRdFreq,
    output logic [pChannels*pWidth-1:0] oDiv,
    output logic [pChannels-1:0]        oStop,
    output logic [pChannels-1:0]        oFreqReflected,
    output logic                        oBusy
);

    localparam int N  = pFreqClock / pTotalPhaseStages;
    localparam int WN = clog2(N + 1);
    localparam logic [pWidth-1:0] cN   = pWidth'(N);
    localparam logic [WN-1:0]     cNum = WN'(N);

    logic [pWidth-1:0]    rTarget [pChannels];
    logic [pWidth-1:0]    rDiv    [pChannels];
    logic [pChannels-1:0] rPending;
    logic [pChannels-1:0] rStop;
    logic [pChannels-1:0] rRefl;

    state_t            rState, nextState;
    logic [CW-1:0]     rPtr, rCapChan, selChan;
    logic [pWidth-1:0] rCapTarget, selTarget, commitDiv;
    logic              anyPending, selFast, wrValid;
    logic              capture, commit, startDiv, commitStop;
    logic              divDone;
    logic [WN-1:0]     divQuot;

    assign wrValid   = iLatchFreqTarget && (int'(iChannel) < pChannels);
    assign selTarget = rTarget[selChan];
    assign selFast   = (selTarget == '0) || (selTarget > cN);
    assign oBusy     = (rState != ST_IDLE);
    assign oStop          = rStop;
    assign oFreqReflected = rRefl;
    assign oRdFreq   = (int'(iRdChannel) < pChannels) ? rTarget[iRdChannel] : '0;

    // Round-robin arbiter: first pending channel at or above the pointer, wrapping.
    always_comb begin
        int idx;
        idx        = 0;
        anyPending = 1'b0;
        selChan    = '0;
        for (int i = 0; i < pChannels; i++) begin
            idx = int'(rPtr) + i;
            if (idx >= pChannels) idx = idx - pChannels;
            if (!anyPending && rPending[idx]) begin
                anyPending = 1'b1;
                selChan    = CW'(idx);
            end
        end
    end

    // Divider FSM next state and control strobes.
    always_comb begin
        nextState = rState;
        capture   = 1'b0;
        startDiv  = 1'b0;
        commit    = 1'b0;
        case (rState)
            ST_IDLE: begin
                if (anyPending) begin
                    capture = 1'b1;
                    if (selFast) begin
                        nextState = ST_COMMIT;
                    end else begin
                        startDiv  = 1'b1;
                        nextState = ST_ITER;
                    end
                end
            end
            ST_ITER:   if (divDone) nextState = ST_COMMIT;
            ST_COMMIT: begin
                commit    = 1'b1;
                nextState = ST_IDLE;
            end
            default:   nextState = ST_IDLE;
        endcase
    end

    // Result written back for the captured channel.
    always_comb begin
        commitDiv  = pWidth'(1);
        commitStop = 1'b0;
        if (rCapTarget == '0) begin
            commitStop = 1'b1;
        end else if (rCapTarget <= cN) begin
            commitDiv          = '0;
            commitDiv[WN-1:0]  = divQuot;
        end
    end

    // FSM state, round-robin pointer and captured job.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            rState     <= ST_IDLE;
            rPtr       <= '0;
            rCapChan   <= '0;
            rCapTarget <= '0;
        end else begin
            rState <= nextState;
            if (capture) begin
                rCapChan   <= selChan;
                rCapTarget <= selTarget;
                rPtr       <= (int'(selChan) == pChannels - 1) ? '0 : selChan + 1'b1;
            end
        end
    end

    // Per-channel target, pending, divider, stop and reflected state.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            // NOTE: these small register arrays are reset explicitly because outputs and arbitration depend on them from the first cycle.
            for (int k = 0; k < pChannels; k++) begin
                rTarget[k] <= '0;
                rDiv[k]    <= pWidth'(1);
            end
            rPending <= '0;
            rStop    <= '1;
            rRefl    <= '1;
        end else begin
            for (int k = 0; k < pChannels; k++) begin
                if (wrValid && iChannel == CW'(k)) begin
                    // A write beats a same-edge capture or commit of this channel.
                    rTarget[k]  <= iFreqTarget;
                    rPending[k] <= 1'b1;
                    rRefl[k]    <= 1'b0;
                end else begin
                    if (capture && selChan == CW'(k)) rPending[k] <= 1'b0;
                    if (commit && rCapChan == CW'(k) && !rPending[k]) rRefl[k] <= 1'b1;
                end
                if (commit && rCapChan == CW'(k)) begin
                    rDiv[k]  <= commitDiv;
                    rStop[k] <= commitStop;
                end
            end
        end
    end

    // Flatten the divider array onto the output bus.
    always_comb begin
        oDiv = '0;
        for (int k = 0; k < pChannels; k++) begin
            oDiv[k*pWidth +: pWidth] = rDiv[k];
        end
    end

    mbldcm_udiv_seq #(
        .WN     (WN),
        .pWidth (pWidth)
    ) uDiv (
        .iClock (iClock),
        .iReset (iReset),
        .iStart (startDiv),
        .iNum   (cNum),
        .iDen   (rCapTarget & '0 | selTarget),
        .oDone  (divDone),
        .oQuot  (divQuot)
    );

endmodule
